vga_rx_checker: RTL and testbench
=================================

Name: vga_rx_checker

Overview:
- Receive-side monitor for the VGA pixel stream produced by the pattern generator.
- Inputs: HSYNC, VSYNC and 8-bit RGB. Recovers line and frame timing from the sync edges only, with no access to HCNT/VCNT.
- Measures total line length, lines per frame and active-region width/height; counts pixels that differ from an expected colour.
- Used in simulation and on FPGA as a loopback self-check of the display path.

Parameters:
- H_TOTAL, 800, expected PCK cycles per line.
- V_TOTAL, 525, expected lines per frame.
- SYNC_ACT, 0, asserted level of HS/VS (0 = active-low).
- LOCK_FRAMES, 2, consecutive in-spec frames required to declare lock (1..7).

Ports:
- PCK  in  1  pixel clock; all logic on posedge.
- RST  in  1  synchronous reset, active-high.
- VGA_HS  in  1  horizontal sync.
- VGA_VS  in  1  vertical sync.
- VGA_R  in  8  red.
- VGA_G  in  8  green.
- VGA_B  in  8  blue.
- EXP_RGB  in  24  expected active colour {R,G,B}; quasi-static.
- LOCKED  out  1  timing matched H_TOTAL/V_TOTAL for LOCK_FRAMES frames.
- MEAS_HTOTAL  out  10  last measured line length in PCK cycles, saturating at 1023.
- MEAS_VTOTAL  out  10  last measured lines per frame, saturating at 1023.
- ACT_W  out  10  max non-black pixels on any line of the last frame.
- ACT_H  out  10  non-black lines in the last frame.
- ERR_CNT  out  16  mismatching active pixels while locked, saturating.
- FRAME_DONE  out  1  one-cycle pulse; all measurement outputs updated in the same cycle.

Behaviour:
- Reset: every output is 0, every internal counter is 0, FSM is UNLOCK. A reset applied mid-frame discards that partial frame.
- Input stage: HS, VS and RGB are each registered once. A sync start is when the registered sync equals SYNC_ACT and the previous registered value did not.
- Horizontal counter hcnt:
  - Cleared to 0 at an HS start.
  - Otherwise increments by 1 per cycle, saturating at 1023.
  - At each HS start, line_len <= hcnt+1. Two HS starts N cycles apart give line_len = N; a missing HS gives 1024, which saturates to 1023 in MEAS_HTOTAL.
- Pixel counting: a pixel is active when the registered RGB != 24'h0.
  - pix_cnt counts active pixels since the last HS start.
  - At an HS start: if pix_cnt != 0, increment the line count and update max_w; then clear pix_cnt.
  - If a pixel is active in the same cycle as an HS start, it is counted in the new line.
- Vertical counter vcnt:
  - Counts HS starts since the last VS start.
  - At a VS start: frame_lines = vcnt + (HS start in the same cycle ? 1 : 0); then vcnt <= 0.
  - Saturates at 1023.
- Frame close, at a VS start, registered and visible on the next PCK edge:
  - MEAS_HTOTAL <= line_len.
  - MEAS_VTOTAL <= frame_lines.
  - ACT_W <= max_w.
  - ACT_H <= active line count.
  - FRAME_DONE pulses high for 1 cycle.
  - Per-frame accumulators are cleared.
  - If HS and VS start in the same cycle, the line closes first and is counted in the frame being closed.
- Latency: 2 PCK edges from the first edge that samples the asserted VS pin to FRAME_DONE high.
- The first VS start after reset closes a partial frame. It updates the outputs but is not evaluated for lock.
- Lock FSM, evaluated on each frame close. A frame is good when frame_lines == V_TOTAL and line_len == H_TOTAL on every line of the frame (sticky per-frame mismatch flag).
  - UNLOCK -> ACQ on the first VS start.
  - ACQ: good frame -> good_cnt++, and when good_cnt reaches LOCK_FRAMES, go to LOCK. Bad frame -> good_cnt = 0, stay in ACQ.
  - LOCK: bad frame -> ACQ with good_cnt = 0, and LOCKED drops in the FRAME_DONE cycle.
  - LOCKED = (state == LOCK).
- ERR_CNT:
  - Increments once per active pixel whose value != EXP_RGB, only while in LOCK.
  - Saturates at 16'hFFFF.
  - Not cleared when lock is lost; cleared only by RST.

Decomposition:
- Shared package (existing VGA parameter include): H_TOTAL/V_TOTAL defaults and the lock FSM state encoding (UNLOCK=0, ACQ=1, LOCK=2).
- One sub-module, vga_sync_edge: input register, previous-value flop and polarity-aware start detect. Instantiated for HS and VS.

Test Plan:
- 800x525 timing, 96-cycle sync, black outside a 640x480 window of EXP_RGB=24'hFF00FF:
  - FRAME_DONE after each frame with MEAS_HTOTAL=800, MEAS_VTOTAL=525, ACT_W=640, ACT_H=480.
  - LOCKED=1 after frame close 3 (1 partial + 2 good).
  - ERR_CNT=0.
- Once locked, force one pixel to 24'h00FF00 -> ERR_CNT=1 at frame end; LOCKED stays 1.
- Stretch one line to 801 cycles -> LOCKED=0 at that frame's FRAME_DONE; back to 1 after 2 further good frames; ERR_CNT retained.
- Assert RST for 1 cycle mid-line -> next cycle all outputs 0, FSM UNLOCK; lock is reacquired after 3 frame closes.
- Suppress HS for 2000 cycles -> MEAS_HTOTAL=1023 and loss of lock. Frame of all 24'h0000FF while locked, expecting 24'hFF00FF -> 307200 errors, so ERR_CNT=16'hFFFF and holds.

Source files
------------

// File: rtl/vga_rx_checker_pkg.sv
// Shared VGA receive-checker definitions: timing defaults, lock FSM encoding,
// measurement payload and saturation helper.
package vga_rx_checker_pkg;

  localparam int unsigned H_TOTAL_DEF = 800;
  localparam int unsigned V_TOTAL_DEF = 525;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned LEN_W = CNT_W + 1;
  localparam int unsigned ERR_W = 16;
  localparam int unsigned RGB_W = 24;
  localparam int unsigned GOOD_W = 3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  localparam logic [1:0] ST_UNLOCK = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_LOCK   = 2'd2;

  typedef struct packed {
    logic [CNT_W-1:0] htotal;
    logic [CNT_W-1:0] vtotal;
    logic [CNT_W-1:0] act_w;
    logic [CNT_W-1:0] act_h;
  } frame_meas_t;

  // Clamp an 11-bit length (max 1024) into the 10-bit reported range.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [LEN_W-1:0] v);
    return v[CNT_W] ? CNT_MAX : v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one sync input and flags the first cycle its registered value
// reaches the asserted level.
module vga_sync_edge
  import vga_rx_checker_pkg::*;
#(
  parameter logic ACT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic start_c
);

  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_in;
      prev_q <= sync_q;
    end
  end

  assign start_c = (sync_q == ACT) && (prev_q != ACT);

endmodule

// File: rtl/vga_rx_checker.sv
// Receive-side VGA monitor: recovers line/frame timing from sync edges,
// measures geometry, tracks lock and counts colour mismatches while locked.
module vga_rx_checker
  import vga_rx_checker_pkg::*;
#(
  parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
  parameter logic        SYNC_ACT    = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic             PCK,
  input  logic             RST,
  input  logic             VGA_HS,
  input  logic             VGA_VS,
  input  logic [7:0]       VGA_R,
  input  logic [7:0]       VGA_G,
  input  logic [7:0]       VGA_B,
  input  logic [RGB_W-1:0] EXP_RGB,
  output logic             LOCKED,
  output logic [CNT_W-1:0] MEAS_HTOTAL,
  output logic [CNT_W-1:0] MEAS_VTOTAL,
  output logic [CNT_W-1:0] ACT_W,
  output logic [CNT_W-1:0] ACT_H,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             FRAME_DONE
);

  logic hs_start_c;
  logic vs_start_c;

  vga_sync_edge #(.ACT(SYNC_ACT)) u_hs_edge (
    .clk     (PCK),
    .rst     (RST),
    .sync_in (VGA_HS),
    .start_c (hs_start_c)
  );

  vga_sync_edge #(.ACT(SYNC_ACT)) u_vs_edge (
    .clk     (PCK),
    .rst     (RST),
    .sync_in (VGA_VS),
    .start_c (vs_start_c)
  );

  logic [RGB_W-1:0] rgb_q;
  logic [CNT_W-1:0] hcnt;
  logic [LEN_W-1:0] line_len;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] vcnt;
  logic [CNT_W-1:0] act_lines;
  logic [CNT_W-1:0] max_w;
  logic             line_bad;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_cnt_nx;

  frame_meas_t      meas_q;
  logic [ERR_W-1:0] err_q;
  logic             done_q;
  logic             locked_q;

  logic             active_c;
  logic             err_hit_c;
  logic [LEN_W-1:0] len_new_c;
  logic [LEN_W-1:0] lines_new_c;
  logic [LEN_W-1:0] line_len_c;
  logic [CNT_W-1:0] max_w_c;
  logic [CNT_W-1:0] act_lines_c;
  logic             line_bad_c;
  logic             frame_good_c;
  logic [GOOD_W:0]  good_inc_c;

  assign active_c  = (rgb_q != '0);
  assign err_hit_c = active_c && (rgb_q != EXP_RGB) && (state == ST_LOCK);

  // Accumulators as seen after the line ending this cycle closes, so a
  // coincident HS/VS lands the line in the frame being closed.
  assign len_new_c    = LEN_W'(hcnt) + LEN_W'(1);
  assign lines_new_c  = LEN_W'(vcnt) + LEN_W'(hs_start_c);
  assign line_len_c   = hs_start_c ? len_new_c : line_len;
  assign max_w_c      = (hs_start_c && (pix_cnt > max_w)) ? pix_cnt : max_w;
  assign act_lines_c  = (hs_start_c && (pix_cnt != '0) && (act_lines != CNT_MAX))
                        ? act_lines + 1'b1 : act_lines;
  assign line_bad_c   = line_bad || (hs_start_c && (len_new_c != LEN_W'(H_TOTAL)));
  assign frame_good_c = !line_bad_c && (lines_new_c == LEN_W'(V_TOTAL));
  assign good_inc_c   = (GOOD_W+1)'(good_cnt) + (GOOD_W+1)'(1);

  always_ff @(posedge PCK) begin
    if (RST) begin
      rgb_q     <= '0;
      hcnt      <= '0;
      line_len  <= '0;
      pix_cnt   <= '0;
      vcnt      <= '0;
      act_lines <= '0;
      max_w     <= '0;
      line_bad  <= 1'b0;
    end else begin
      rgb_q <= {VGA_R, VGA_G, VGA_B};
      if (hs_start_c) begin
        hcnt     <= '0;
        line_len <= len_new_c;
        pix_cnt  <= CNT_W'(active_c);
      end else begin
        if (hcnt != CNT_MAX) hcnt <= hcnt + 1'b1;
        if (active_c && (pix_cnt != CNT_MAX)) pix_cnt <= pix_cnt + 1'b1;
      end
      if (vs_start_c) begin
        vcnt      <= '0;
        act_lines <= '0;
        max_w     <= '0;
        line_bad  <= 1'b0;
      end else begin
        if (hs_start_c && (vcnt != CNT_MAX)) vcnt <= vcnt + 1'b1;
        act_lines <= act_lines_c;
        max_w     <= max_w_c;
        line_bad  <= line_bad_c;
      end
    end
  end

  always_ff @(posedge PCK) begin
    if (RST) begin
      state    <= ST_UNLOCK;
      good_cnt <= '0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_cnt_nx;
    end
  end

  // Lock FSM: advances only on frame close; the first close just arms it.
  always_comb begin
    state_nx    = state;
    good_cnt_nx = good_cnt;
    if (vs_start_c) begin
      case (state)
        ST_UNLOCK: begin
          state_nx    = ST_ACQ;
          good_cnt_nx = '0;
        end
        ST_ACQ: begin
          if (!frame_good_c) begin
            good_cnt_nx = '0;
          end else if (good_inc_c >= (GOOD_W+1)'(LOCK_FRAMES)) begin
            state_nx    = ST_LOCK;
            good_cnt_nx = '0;
          end else begin
            good_cnt_nx = good_inc_c[GOOD_W-1:0];
          end
        end
        ST_LOCK: begin
          if (!frame_good_c) begin
            state_nx    = ST_ACQ;
            good_cnt_nx = '0;
          end
        end
        default: begin
          state_nx    = ST_UNLOCK;
          good_cnt_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge PCK) begin
    if (RST) begin
      meas_q   <= '0;
      err_q    <= '0;
      done_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      done_q   <= vs_start_c;
      locked_q <= (state_nx == ST_LOCK);
      if (vs_start_c) begin
        meas_q.htotal <= sat_cnt(line_len_c);
        meas_q.vtotal <= sat_cnt(lines_new_c);
        meas_q.act_w  <= max_w_c;
        meas_q.act_h  <= act_lines_c;
      end
      if (err_hit_c && (err_q != ERR_MAX)) err_q <= err_q + 1'b1;
    end
  end

  assign LOCKED      = locked_q;
  assign MEAS_HTOTAL = meas_q.htotal;
  assign MEAS_VTOTAL = meas_q.vtotal;
  assign ACT_W       = meas_q.act_w;
  assign ACT_H       = meas_q.act_h;
  assign ERR_CNT     = err_q;
  assign FRAME_DONE  = done_q;

endmodule

// File: tb/tb_vga_rx_checker.sv
// Bench for vga_rx_checker: randomized VGA stream on scaled 32x16 timing,
// frame-level reference model feeding a scoreboard checked on FRAME_DONE.
module tb_vga_rx_checker;

  localparam int unsigned HT = 32;
  localparam int unsigned VT = 16;
  localparam int unsigned LF = 2;
  localparam logic [23:0] EXP = 24'hFF00FF;
  localparam int HS_W = 4;
  localparam int VS_L = 2;
  localparam int WX0 = 8;
  localparam int WX1 = 27;
  localparam int WY0 = 3;
  localparam int WY1 = 14;

  logic        PCK = 1'b0;
  logic        RST;
  logic        VGA_HS;
  logic        VGA_VS;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic [23:0] EXP_RGB;
  logic        LOCKED;
  logic [9:0]  MEAS_HTOTAL;
  logic [9:0]  MEAS_VTOTAL;
  logic [9:0]  ACT_W;
  logic [9:0]  ACT_H;
  logic [15:0] ERR_CNT;
  logic        FRAME_DONE;

  vga_rx_checker #(
    .H_TOTAL(HT), .V_TOTAL(VT), .SYNC_ACT(1'b0), .LOCK_FRAMES(LF)
  ) dut (
    .PCK(PCK), .RST(RST), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .EXP_RGB(EXP_RGB),
    .LOCKED(LOCKED), .MEAS_HTOTAL(MEAS_HTOTAL), .MEAS_VTOTAL(MEAS_VTOTAL),
    .ACT_W(ACT_W), .ACT_H(ACT_H), .ERR_CNT(ERR_CNT), .FRAME_DONE(FRAME_DONE)
  );

  always #5 PCK = ~PCK;

  typedef struct {
    int cyc;
    int ht;
    int vt;
    int aw;
    int ah;
    int err;
    int lk;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  bit   rst_seen = 1'b0;
  bit   done = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge PCK) begin
    cyc      <= cyc + 1;
    rst_seen <= RST;
  end

  // Reference model state, in terms of pin-sample times.
  bit m_prev_hs, m_prev_vs;
  int m_last_hs, m_len, m_pix, m_lines, m_act, m_maxw, m_mode, m_streak, m_err;
  bit m_bad;
  bit          p_valid = 1'b0;
  int          p_t;
  bit          p_hs, p_vs;
  logic [23:0] p_rgb;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_reset(input int r);
    m_prev_hs = 1'b0; m_prev_vs = 1'b0;
    m_last_hs = r - 1; m_len = 0; m_pix = 0; m_lines = 0; m_act = 0;
    m_maxw = 0; m_bad = 1'b0; m_mode = 0; m_streak = 0; m_err = 0;
  endfunction

  function automatic void model_pin(input int t, input bit hs, input bit vs, input logic [23:0] rgb);
    bit   hs_st, vs_st, good;
    exp_t e;
    hs_st = (hs == 1'b0) && (m_prev_hs != 1'b0);
    vs_st = (vs == 1'b0) && (m_prev_vs != 1'b0);
    m_prev_hs = hs;
    m_prev_vs = vs;
    if (hs_st) begin
      m_len = imin(t - m_last_hs, 1024);
      m_last_hs = t;
      if (m_len != int'(HT)) m_bad = 1'b1;
      if (m_pix > 0) begin
        m_act++;
        m_maxw = (imin(m_pix, 1023) > m_maxw) ? imin(m_pix, 1023) : m_maxw;
      end
      m_pix = 0;
      m_lines++;
    end
    if (rgb != 24'h0) begin
      m_pix++;
      if (m_mode == 2 && rgb != EXP) m_err = imin(m_err + 1, 65535);
    end
    if (vs_st) begin
      good = (m_lines == int'(VT)) && !m_bad;
      if (m_mode == 0) begin
        m_mode = 1; m_streak = 0;
      end else if (m_mode == 1) begin
        if (good) begin
          m_streak++;
          if (m_streak >= int'(LF)) begin m_mode = 2; m_streak = 0; end
        end else m_streak = 0;
      end else if (!good) begin
        m_mode = 1; m_streak = 0;
      end
      e.cyc = t + 1;
      e.ht  = imin(m_len, 1023);
      e.vt  = imin(m_lines, 1023);
      e.aw  = m_maxw;
      e.ah  = imin(m_act, 1023);
      e.err = m_err;
      e.lk  = (m_mode == 2) ? 1 : 0;
      q.push_back(e);
      m_lines = 0; m_act = 0; m_maxw = 0; m_bad = 1'b0;
    end
  endfunction

  // One pin cycle: a pin sampled at edge t is processed at edge t+1 unless reset then.
  task automatic step(input bit hs, input bit vs, input logic [23:0] rgb, input bit rst);
    @(negedge PCK);
    if (rst) begin
      p_valid = 1'b0;
      model_reset(cyc + 1);
    end else begin
      if (p_valid) model_pin(p_t, p_hs, p_vs, p_rgb);
      p_valid = 1'b1;
      p_t = cyc + 1; p_hs = hs; p_vs = vs; p_rgb = rgb;
    end
    RST = rst; VGA_HS = hs; VGA_VS = vs;
    {VGA_R, VGA_G, VGA_B} = rgb;
  endtask

  task automatic run_frame(input int stretch_row, input int rst_row, input int rst_col);
    for (int r = 0; r < int'(VT); r++) begin
      int len;
      len = (r == stretch_row) ? int'(HT) + 1 : int'(HT);
      for (int c = 0; c < len; c++) begin
        logic [23:0] px;
        bit in_win;
        in_win = (r >= WY0) && (r <= WY1) && (c >= WX0) && (c <= WX1);
        px = in_win ? EXP : 24'h0;
        if (in_win && $urandom_range(0, 149) == 0)
          px = ($urandom_range(0, 3) == 0) ? 24'h0 : (24'h00FF00 | 24'($urandom_range(0, 255)));
        else if (!in_win && $urandom_range(0, 399) == 0)
          px = EXP;
        step(c >= HS_W, r >= VS_L, px, (r == rst_row) && (c == rst_col));
      end
    end
  endtask

  initial begin : driver
    RST = 1'b1; VGA_HS = 1'b1; VGA_VS = 1'b1;
    VGA_R = 8'h0; VGA_G = 8'h0; VGA_B = 8'h0; EXP_RGB = EXP;
    repeat (3) step(1'b1, 1'b1, 24'h0, 1'b1);
    repeat (5) step(1'b1, 1'b1, 24'h0, 1'b0);
    repeat (6) run_frame(-1, -1, -1);
    run_frame(7, -1, -1);
    repeat (3) run_frame(-1, -1, -1);
    run_frame(-1, 5, 10);
    repeat (4) run_frame(-1, -1, -1);
    // Long HS-less stretch of wrong colour while locked: saturates ERR_CNT.
    repeat (66000) step(1'b1, 1'b1, 24'h0000FF, 1'b0);
    repeat (4) run_frame(-1, -1, -1);
    repeat (4) step(1'b1, 1'b1, 24'h0, 1'b0);
    done = 1'b1;
  end

  function automatic void chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge PCK);
      if (rst_seen) begin
        chk("rst_locked", int'(LOCKED), 0);
        chk("rst_htotal", int'(MEAS_HTOTAL), 0);
        chk("rst_vtotal", int'(MEAS_VTOTAL), 0);
        chk("rst_act_w", int'(ACT_W), 0);
        chk("rst_act_h", int'(ACT_H), 0);
        chk("rst_err_cnt", int'(ERR_CNT), 0);
        chk("rst_frame_done", int'(FRAME_DONE), 0);
      end
      if (FRAME_DONE === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_frame_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("meas_htotal", int'(MEAS_HTOTAL), e.ht);
          chk("meas_vtotal", int'(MEAS_VTOTAL), e.vt);
          chk("act_w", int'(ACT_W), e.aw);
          chk("act_h", int'(ACT_H), e.ah);
          chk("err_cnt", int'(ERR_CNT), e.err);
          chk("locked", int'(LOCKED), e.lk);
        end
      end
      if (q.size() > 0 && cyc > q[0].cyc) begin
        chk("missing_frame_done", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (done) begin
        chk("pending_frames", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

endmodule
